// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode constants, datapath select codes and the packed control word.
package mips_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_RWB    = 4'd4,
        S_MADDR  = 4'd5,
        S_MREAD  = 4'd6,
        S_MWB    = 4'd7,
        S_MWRITE = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_AEXEC  = 4'd11,
        S_AWB    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_RT       = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_SUB   = 2'b01;
    localparam logic [1:0] ULA_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ULA    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] ula_operation;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
        logic       bus_err;
    } ctrl_t;

    // States that talk to memory and therefore wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MREAD) || (s == S_MWRITE);
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_outputs.sv
// State -> control-word decode. Apart from the completion/timeout
// qualifiers in memory states and the illegal-opcode flag in DECODE
// (opcode comes from the registered IR), every field depends on state only.
module mips_multicycle_ctrl_outputs
    import mips_multicycle_ctrl_pkg::*;
(
    input  state_t      state_i,
    input  logic [5:0]  opcode_i,
    input  logic        mem_ready_i,
    input  logic        timeout_i,
    output ctrl_t       ctrl_o
);

    logic timed_out;
    assign timed_out = !mem_ready_i && timeout_i;

    // Control word for the current micro-step, all-zero by default.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read      = 1'b1;
                ctrl_o.ir_write      = 1'b1;
                ctrl_o.alu_src_b     = SRCB_FOUR;
                ctrl_o.ula_operation = ULA_ADD;
                ctrl_o.pc_write      = mem_ready_i;
                ctrl_o.bus_err       = timed_out;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b     = SRCB_SEXT_SH2;
                ctrl_o.ula_operation = ULA_ADD;
                ctrl_o.illegal_op    = !is_legal_op(opcode_i);
            end
            S_EXEC: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.ula_operation = ULA_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MADDR, S_AEXEC: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_SEXT;
                ctrl_o.ula_operation = ULA_ADD;
            end
            S_MREAD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
                ctrl_o.bus_err  = timed_out;
            end
            S_MWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MWRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
                ctrl_o.bus_err    = timed_out;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.ula_operation = ULA_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_AWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// memory wait counter. The control word is decoded in a sub-module.
// Handshake: a memory access completes on any clock where the FSM is in a
// memory state and mem_ready_i is 1; strobes stay up for the whole wait,
// and mem_ready_i has no effect in any other state.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] ula_operation_o,
    output logic [1:0] pc_source_o,
    output logic       instr_done_o,
    output logic       illegal_op_o,
    output logic       bus_err_o,
    output logic [3:0] state_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout;
    ctrl_t            ctrl;

    assign timeout = (wait_cnt_q == TIMEOUT_C);

    // State and wait-counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state; a timed-out access abandons the instruction and refetches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i)  state_d = S_DECODE;
                else if (timeout) state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_AEXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_EXEC:   state_d = S_RWB;
            S_MADDR:  state_d = (opcode_i == OP_LW) ? S_MREAD : S_MWRITE;
            S_MREAD: begin
                if (mem_ready_i)  state_d = S_MWB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MWRITE: begin
                if (mem_ready_i || timeout) state_d = S_FETCH;
            end
            S_AEXEC:  state_d = S_AWB;
            S_RWB, S_MWB, S_BRANCH, S_JUMP, S_AWB: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Count stalled cycles; any completion, timeout or non-memory state
    // leaves the counter at zero, so each memory state is entered with 0.
    always_comb begin
        wait_cnt_d = '0;
        if (is_mem_state(state_q) && !mem_ready_i && !timeout)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    mips_multicycle_ctrl_outputs u_outputs (
        .state_i     (state_q),
        .opcode_i    (opcode_i),
        .mem_ready_i (mem_ready_i),
        .timeout_i   (timeout),
        .ctrl_o      (ctrl)
    );

    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign i_or_d_o        = ctrl.i_or_d;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign ir_write_o      = ctrl.ir_write;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign reg_dst_o       = ctrl.reg_dst;
    assign reg_write_o     = ctrl.reg_write;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign ula_operation_o = ctrl.ula_operation;
    assign pc_source_o     = ctrl.pc_source;
    assign instr_done_o    = ctrl.instr_done;
    assign illegal_op_o    = ctrl.illegal_op;
    assign bus_err_o       = ctrl.bus_err;
    assign state_o         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl, built with TIMEOUT=3.
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC   = 4'd3;
    localparam logic [3:0] ST_RWB    = 4'd4;
    localparam logic [3:0] ST_MADDR  = 4'd5;
    localparam logic [3:0] ST_MREAD  = 4'd6;
    localparam logic [3:0] ST_MWB    = 4'd7;
    localparam logic [3:0] ST_MWRITE = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;
    localparam logic [3:0] ST_JUMP   = 4'd10;
    localparam logic [3:0] ST_AEXEC  = 4'd11;
    localparam logic [3:0] ST_AWB    = 4'd12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, ula_operation, pc_source;
    logic       instr_done, illegal_op, bus_err;
    logic [3:0] state;
    logic [18:0] word;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.TIMEOUT(3), .CNT_W(8)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .opcode_i        (opcode),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .i_or_d_o        (i_or_d),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .mem_to_reg_o    (mem_to_reg),
        .reg_dst_o       (reg_dst),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .ula_operation_o (ula_operation),
        .pc_source_o     (pc_source),
        .instr_done_o    (instr_done),
        .illegal_op_o    (illegal_op),
        .bus_err_o       (bus_err),
        .state_o         (state)
    );

    assign word = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                   ula_operation, pc_source, instr_done, illegal_op, bus_err};

    // Pack a control word in the same field order as 'word' above.
    function automatic logic [18:0] mk(input logic pcw, pcc, iod, mr, mw, irw,
                                       m2r, rd, rw, a, input logic [1:0] b, op, ps,
                                       input logic done, ill, berr);
        return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, a, b, op, ps, done, ill, berr};
    endfunction

    logic [18:0] w_zero, w_fetch_go, w_fetch_wait, w_decode, w_decode_ill, w_exec, w_rwb;
    logic [18:0] w_maddr, w_mread, w_mwb, w_mwrite_wait, w_mwrite_done, w_mwrite_to;
    logic [18:0] w_branch, w_jump, w_aexec, w_awb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then compare state and control word.
    task automatic chk(input string tag, input logic [3:0] exp_st, input logic [18:0] exp_w);
        #1;
        checks++;
        assert (state === exp_st) else begin
            errors++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, state, exp_st);
        end
        checks++;
        assert (word === exp_w) else begin
            errors++;
            $error("FAIL %s ctrl: observed=%b expected=%b", tag, word, exp_w);
        end
    endtask

    initial begin
        //                 pcw pcc iod mr mw irw m2r rd rw a  b      op     ps  done ill berr
        w_zero        = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        w_fetch_go    = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
        w_fetch_wait  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
        w_decode      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
        w_decode_ill  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1, 0);
        w_exec        = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0);
        w_rwb         = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        w_maddr       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        w_mread       = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        w_mwb         = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        w_mwrite_wait = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        w_mwrite_done = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        w_mwrite_to   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        w_branch      = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0, 0);
        w_jump        = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0);
        w_aexec       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        w_awb         = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0);

        // Reset held low for 3 cycles with mem_ready high: outputs stay 0.
        rst_n = 1'b0;
        opcode = 6'b000000;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold", ST_IDLE, w_zero);
        end
        rst_n = 1'b1;
        chk("reset_release", ST_IDLE, w_zero);
        tick();

        // R-type: FETCH, DECODE, EXEC, RWB.
        chk("r_fetch", ST_FETCH, w_fetch_go);   tick();
        chk("r_decode", ST_DECODE, w_decode);   tick();
        chk("r_exec", ST_EXEC, w_exec);         tick();
        chk("r_rwb", ST_RWB, w_rwb);            tick();

        // lw with 3 stall cycles in MREAD: 8 cycles in total.
        opcode = 6'b100011;
        chk("lw_fetch", ST_FETCH, w_fetch_go);  tick();
        chk("lw_decode", ST_DECODE, w_decode);  tick();
        chk("lw_maddr", ST_MADDR, w_maddr);     tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lw_mread_wait", ST_MREAD, w_mread);
            tick();
        end
        mem_ready = 1'b1;
        chk("lw_mread_done", ST_MREAD, w_mread); tick();
        chk("lw_mwb", ST_MWB, w_mwb);            tick();

        // beq: 3 cycles.
        opcode = 6'b000100;
        chk("beq_fetch", ST_FETCH, w_fetch_go); tick();
        chk("beq_decode", ST_DECODE, w_decode); tick();
        chk("beq_branch", ST_BRANCH, w_branch); tick();

        // j: 3 cycles.
        opcode = 6'b000010;
        chk("j_fetch", ST_FETCH, w_fetch_go);   tick();
        chk("j_decode", ST_DECODE, w_decode);   tick();
        chk("j_jump", ST_JUMP, w_jump);         tick();

        // addi: 4 cycles.
        opcode = 6'b001000;
        chk("addi_fetch", ST_FETCH, w_fetch_go); tick();
        chk("addi_decode", ST_DECODE, w_decode); tick();
        chk("addi_aexec", ST_AEXEC, w_aexec);    tick();
        chk("addi_awb", ST_AWB, w_awb);          tick();

        // Illegal opcode, with one FETCH stall first.
        opcode = 6'b111111;
        mem_ready = 1'b0;
        chk("ill_fetch_wait", ST_FETCH, w_fetch_wait); tick();
        mem_ready = 1'b1;
        chk("ill_fetch", ST_FETCH, w_fetch_go);        tick();
        chk("ill_decode", ST_DECODE, w_decode_ill);    tick();

        // sw timing out: bus_err on the 4th MWRITE cycle, then FETCH.
        opcode = 6'b101011;
        chk("swto_fetch", ST_FETCH, w_fetch_go);  tick();
        chk("swto_decode", ST_DECODE, w_decode);  tick();
        chk("swto_maddr", ST_MADDR, w_maddr);     tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("swto_mwrite_wait", ST_MWRITE, w_mwrite_wait);
            tick();
        end
        chk("swto_timeout", ST_MWRITE, w_mwrite_to); tick();
        chk("swto_refetch", ST_FETCH, w_fetch_wait);
        mem_ready = 1'b1;
        tick();

        // sw completing in the very cycle the counter reaches TIMEOUT.
        chk("swlate_decode", ST_DECODE, w_decode); tick();
        chk("swlate_maddr", ST_MADDR, w_maddr);    tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("swlate_mwrite_wait", ST_MWRITE, w_mwrite_wait);
            tick();
        end
        mem_ready = 1'b1;
        chk("swlate_done", ST_MWRITE, w_mwrite_done); tick();
        chk("swlate_fetch", ST_FETCH, w_fetch_go);    tick();

        // sw interrupted by reset while waiting in MWRITE.
        chk("swrst_decode", ST_DECODE, w_decode); tick();
        chk("swrst_maddr", ST_MADDR, w_maddr);    tick();
        mem_ready = 1'b0;
        chk("swrst_mwrite", ST_MWRITE, w_mwrite_wait);
        #1;
        rst_n = 1'b0;
        chk("swrst_async", ST_IDLE, w_zero);
        mem_ready = 1'b1;
        tick();
        chk("swrst_held", ST_IDLE, w_zero);
        rst_n = 1'b1;
        tick();
        chk("swrst_refetch", ST_FETCH, w_fetch_go);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
